// File: rtl/inv_sbox_iter.sv
// Iterative AES InvSubBytes over a 128-bit state, LANES bytes per cycle.
// Define INV_SBOX_FWD_EN to add port enc selecting the forward SBox.
module inv_sbox_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
`ifdef INV_SBOX_FWD_EN
  ,
  input  logic         enc
`endif
);

  localparam int NG = 16 / LANES;
  localparam logic [3:0] LAST = 4'(NG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [3:0]   r_grp;
  logic [127:0] r_work;
  logic [127:0] w_next;
  logic         w_enc;

  function automatic logic [7:0] f_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 is the field inverse, and maps 0 to 0 as AES requires
  function automatic logic [7:0] f_inv(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = f_mul(p, p);
      r = f_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] f_aff(input logic [7:0] b);
    return b
      ^ {b[6:0], b[7]}
      ^ {b[5:0], b[7:6]}
      ^ {b[4:0], b[7:5]}
      ^ {b[3:0], b[7:4]}
      ^ 8'h63;
  endfunction

  function automatic logic [7:0] f_iaff(input logic [7:0] s);
    return {s[6:0], s[7]}
      ^ {s[4:0], s[7:5]}
      ^ {s[1:0], s[7:2]}
      ^ 8'h05;
  endfunction

  function automatic logic [7:0] f_sub(
    input logic [7:0] x,
    input logic       e
  );
    logic [7:0] g;
    g = f_inv(e ? x : f_iaff(x));
    return e ? f_aff(g) : g;
  endfunction

`ifdef INV_SBOX_FWD_EN
  logic r_enc;

  always_ff @(posedge clk) begin
    if (!rst_n)
      r_enc <= 1'b0;
    else if (r_state == S_IDLE && in_valid)
      r_enc <= enc;
  end

  assign w_enc = r_enc;
`else
  assign w_enc = 1'b0;
`endif

  always_comb begin
    int pos;
    pos = 0;
    w_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      pos = int'(4'(int'(r_grp) * LANES + l));
      w_next[8*(15-pos) +: 8] = f_sub(r_work[8*(15-pos) +: 8], w_enc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grp   <= '0;
      r_work  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_work  <= data_in;
            r_grp   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_work <= w_next;
          if (r_grp == LAST) begin
            r_grp   <= '0;
            r_state <= S_DONE;
          end else begin
            r_grp <= r_grp + 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_grp   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  // gate so a partially substituted state is never visible
  assign data_out  = (r_state == S_DONE) ? r_work : '0;

endmodule

// File: tb/tb_inv_sbox_iter.sv
// Randomized self-checking bench for inv_sbox_iter.
// Reference SBox built by brute-force field inversion.
module tb_inv_sbox_iter;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] data_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] data_out;
  logic         busy;
  logic         enc;

  logic         g_valid;
  logic [127:0] g_data;
  logic [4:0]   g_ov;
  logic [4:0]   g_ir;
  logic [4:0]   g_bz;
  logic [127:0] g_do [5];

  int n_chk;
  int n_err;
  int cyc;

  logic [7:0] sb  [256];
  logic [7:0] isb [256];

  inv_sbox_iter #(.LANES(4)) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in(data_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .data_out(data_out),
    .busy(busy)
`ifdef INV_SBOX_FWD_EN
    ,
    .enc(enc)
`endif
  );

  for (genvar g = 0; g < 5; g++) begin : g_lanes
    inv_sbox_iter #(.LANES(1 << g)) u_g (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(g_valid),
      .in_ready(g_ir[g]),
      .data_in(g_data),
      .out_valid(g_ov[g]),
      .out_ready(1'b1),
      .data_out(g_do[g]),
      .busy(g_bz[g])
`ifdef INV_SBOX_FWD_EN
      ,
      .enc(1'b0)
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--)
      if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables;
    logic [7:0] v;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8]
             ^ v[(i+6)%8] ^ v[(i+7)%8] ^ ((8'h63 >> i) & 1'b1);
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_sub(
    input logic [127:0] d,
    input bit           fwd
  );
    logic [127:0] r;
    logic [7:0]   b;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      b = d[127-8*i -: 8];
      r[127-8*i -: 8] = fwd ? sb[b] : isb[b];
    end
    return r;
  endfunction

  // pulse a block into the main DUT; returns cycles from capture to out_valid
  task automatic send(
    input  logic [127:0] d,
    input  bit           e,
    output int           lat
  );
    data_in  = d;
    enc      = e;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [127:0] blk;
  logic [127:0] held;
  int           lat;
  int           prev;
  int           gl [5];
  logic [127:0] gd [5];
  int           w;

  initial begin
    cyc = 0;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    data_in = '0;
    out_ready = 1'b1;
    enc = 1'b0;
    g_valid = 1'b0;
    g_data = '0;
    build_tables();

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_data_out", data_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send({16{8'h63}}, 1'b0, lat);
    chk("lat_63", 128'(lat), 128'd4);
    chk("data_63", data_out, 128'd0);
    @(negedge clk);

    send({4{32'h007C16ED}}, 1'b0, lat);
    chk("lat_vec", 128'(lat), 128'd4);
    chk("data_vec", data_out, {4{32'h5201FF53}});
    @(negedge clk);

    g_data  = {4{32'h007C16ED}};
    g_valid = 1'b1;
    @(negedge clk);
    g_valid = 1'b0;
    for (int g = 0; g < 5; g++) gl[g] = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int g = 0; g < 5; g++)
        if (g_ov[g] && gl[g] < 0) begin
          gl[g] = n;
          gd[g] = g_do[g];
        end
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("lanes%0d_lat", 1 << g), 128'(gl[g]), 128'(16 >> g));
      chk($sformatf("lanes%0d_data", 1 << g), gd[g], {4{32'h5201FF53}});
    end

    blk = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 1'b0;
    send(blk, 1'b0, lat);
    chk("stall_lat", 128'(lat), 128'd4);
    held = ref_sub(blk, 1'b0);
    for (int k = 0; k < 10; k++) begin
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = k[0];
      @(negedge clk);
      chk("stall_data", data_out, held);
      chk("stall_in_ready", 128'(in_ready), 128'd0);
      chk("stall_out_valid", 128'(out_valid), 128'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 128'(in_ready), 128'd1);
    chk("release_out_valid", 128'(out_valid), 128'd0);

    data_in  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_in_ready", 128'(in_ready), 128'd1);
    chk("abort_out_valid", 128'(out_valid), 128'd0);
    chk("abort_data_out", data_out, 128'd0);
    blk = {$urandom, $urandom, $urandom, $urandom};
    send(blk, 1'b0, lat);
    chk("fresh_lat", 128'(lat), 128'd4);
    chk("fresh_data", data_out, ref_sub(blk, 1'b0));
    @(negedge clk);

`ifdef INV_SBOX_FWD_EN
    send(128'd0, 1'b1, lat);
    chk("fwd_lat", 128'(lat), 128'd4);
    chk("fwd_data", data_out, {16{8'h63}});
    held = data_out;
    @(negedge clk);
    send(held, 1'b0, lat);
    chk("fwd_back", data_out, 128'd0);
    @(negedge clk);
`endif

    prev = -1;
    enc = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      chk("bb_ready_wait", 128'(in_ready), 128'd1);
      blk = {$urandom, $urandom, $urandom, $urandom};
      data_in = blk;
      if (prev >= 0) chk("bb_interval", 128'(cyc - prev), 128'd6);
      prev = cyc;
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      chk("bb_data", data_out, ref_sub(blk, 1'b0));
    end
    in_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule

// File: doc/inv_sbox_iter.md
INV_SBOX_ITER -- requirements
Module: inv_sbox_iter

Interface
REQ-001 SHALL have parameter LANES, default 4, number of state bytes inverse-substituted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous to clk and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: data_in holds a block to substitute.
REQ-005 SHALL have port in_ready, output, 1 bit: block accepts a new block.
REQ-006 SHALL have port data_in, input, 128 bits: AES state; byte 0 is bits [127:120] and byte 15 is bits [7:0].
REQ-007 SHALL have port out_valid, output, 1 bit: data_out holds a finished result.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-009 SHALL have port data_out, output, 128 bits: InvSubBytes of the accepted data_in, with the same byte ordering as data_in.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the FSM states IDLE, RUN and DONE, with a 4-bit group counter grp.
REQ-012 SHALL drive in_ready=1 only in IDLE, out_valid=1 only in DONE, and busy=1 in RUN and DONE.
REQ-013 SHALL, in IDLE with in_valid=1, capture data_in into a 128-bit working register, clear grp, and go to RUN on that edge.
REQ-014 SHALL, in each RUN cycle, replace working bytes grp*LANES .. grp*LANES+LANES-1 with their FIPS-197 InvSBox values (byte 0 first), then increment grp.
REQ-015 SHALL go from RUN to DONE on the edge that processes the last group (grp = 16/LANES-1), so out_valid rises exactly 16/LANES cycles after the capture edge.
REQ-016 SHALL, in DONE, drive data_out from the working register and hold data_out stable while out_ready=0.
REQ-017 SHALL, in DONE with out_ready=1, complete the output handshake and return to IDLE; a new block can be captured no earlier than the following edge, giving a throughput of one block per 16/LANES+2 cycles.
REQ-018 SHALL ignore in_valid and data_in changes in RUN and DONE; the captured block is not corrupted by them.
REQ-019 SHALL instantiate exactly LANES combinational InvSBox lookups, shared across groups through a byte-group multiplexer indexed by grp.
REQ-020 SHALL treat an unused grp value as a don't-care that can never be reached; grp never exceeds 16/LANES-1.

Reset
REQ-021 SHALL, on a clk edge with rst_n=0, force state IDLE, grp=0, the working register to 0, and data_out=0; outputs SHALL then be in_ready=1, out_valid=0, busy=0.
REQ-022 SHALL, on reset asserted in RUN or DONE, abort the block in progress with no partial result ever presented; reset takes priority over every handshake in the same cycle.

Configuration
REQ-023 SHALL, with macro INV_SBOX_FWD_EN defined, add an input port enc (1 bit) sampled with data_in at capture: enc=1 applies the forward SBox and enc=0 applies InvSBox, both through the same LANES lookups and the same timing.
REQ-024 SHALL, without INV_SBOX_FWD_EN, omit port enc and apply InvSBox only.

Verification
REQ-025 SHALL cover: reset, then data_in=128'h6363...63 with in_valid pulsed and out_ready=1 -> out_valid rises 4 cycles after capture (LANES=4) with data_out=128'h0.
REQ-026 SHALL cover: data_in=128'h00_7C_16_ED repeated 4 times -> data_out=128'h52_01_FF_53 repeated 4 times; run for LANES = 1, 2, 4, 8 and 16, checking latencies of 16, 8, 4, 2 and 1 cycles.
REQ-027 SHALL cover: out_ready held 0 for 10 cycles in DONE while data_in and in_valid toggle -> data_out stays stable, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-028 SHALL cover: rst_n=0 for one cycle during the second RUN cycle -> the next cycle shows in_ready=1, out_valid=0, data_out=0; a fresh block then completes correctly.
REQ-029 SHALL cover: with INV_SBOX_FWD_EN, enc=1 and data_in=128'h0 -> data_out=128'h6363...63; then enc=0 with that result as data_in -> 128'h0.
REQ-030 SHALL cover: 256 random back-to-back blocks with in_valid held high -> every result matches the InvSubBytes reference model, with exactly 16/LANES+2 cycles between accepts.
